// File: rtl/soc_bus_pkg.sv
// Shared types for the CPU-to-slave memory bus router.
//   state_e     : transaction FSM states
//   err_cause_e : encoding reported on err_cause
//   ERROR_WORD_DEFAULT : read data returned when a transaction ends in error
package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNMAPPED = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_RO_WRITE = 2'd3
  } err_cause_e;

  localparam logic [31:0] ERROR_WORD_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mem_bus_router_if.sv
// picorv32 native memory interface as seen between the CPU and the router.
//   cpu_valid/cpu_addr/cpu_wdata/cpu_wstrb : request, driven by the CPU
//   cpu_ready/cpu_rdata                    : completion, driven by the router
// modport master = CPU side, modport slave = router side.
interface mem_bus_router_if #(
  parameter int DATA_W = 32
) ();

  logic                  cpu_valid;
  logic [31:0]           cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic [DATA_W/8-1:0]   cpu_wstrb;
  logic                  cpu_ready;
  logic [DATA_W-1:0]     cpu_rdata;

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ready, cpu_rdata
  );

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ready, cpu_rdata
  );

endinterface

// File: rtl/mem_bus_decode.sv
// Combinational address decoder.
//   region    : top DECODE_BITS of the CPU address
//   hit       : region matches one of the slave IDs
//   idx       : matching slave index (lowest index wins on multiple matches)
//   read_only : the matching slave rejects writes
module mem_bus_decode #(
  parameter int                            N_SLAVES       = 4,
  parameter int                            DECODE_BITS    = 8,
  parameter logic [N_SLAVES*DECODE_BITS-1:0] SLAVE_IDS    = {8'hff, 8'hfe, 8'h01, 8'h00},
  parameter logic [N_SLAVES-1:0]           READ_ONLY_MASK = 4'b0001,
  localparam int                           IDX_W          = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
  input  logic [DECODE_BITS-1:0] region,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx,
  output logic                   read_only
);

  // Scanning from the top index down lets the lowest matching index overwrite
  // any higher one, giving lowest-index priority without a separate encoder.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one
    // unassigned, which would otherwise infer a latch.
    hit       = 1'b0;
    idx       = '0;
    read_only = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (region == SLAVE_IDS[i*DECODE_BITS +: DECODE_BITS]) begin
        hit       = 1'b1;
        idx       = IDX_W'(i);
        read_only = READ_ONLY_MASK[i];
      end
    end
  end

endmodule

// File: rtl/mem_bus_router.sv
// Routes picorv32 native memory transactions to N slave channels through a
// single registered IDLE/ACCESS/DONE transaction FSM, with an address map,
// read-only regions, a wait-state timeout and sticky error reporting.
//   clk, n_reset : clock, asynchronous active-low reset
//   cpu          : CPU request/completion bus (router side)
//   s_valid      : one-hot per-slave request
//   s_addr/s_wdata/s_wstrb : shared request fields (wstrb zeroed when idle)
//   s_ready/s_rdata        : per-slave completion and read data
//   err_clear    : clears err_flag
//   err_flag/err_cause/err_addr : sticky error flag, latest cause and address
module mem_bus_router
  import soc_bus_pkg::*;
#(
  parameter int                              N_SLAVES       = 4,
  parameter int                              DATA_W         = 32,
  parameter int                              DECODE_BITS    = 8,
  parameter logic [N_SLAVES*DECODE_BITS-1:0] SLAVE_IDS      = {8'hff, 8'hfe, 8'h01, 8'h00},
  parameter logic [N_SLAVES-1:0]             READ_ONLY_MASK = 4'b0001,
  parameter int                              TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0]               ERROR_WORD     = DATA_W'(ERROR_WORD_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     n_reset,
  mem_bus_router_if.slave          cpu,
  output logic [N_SLAVES-1:0]      s_valid,
  output logic [31:0]              s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  output logic [DATA_W/8-1:0]      s_wstrb,
  input  logic [N_SLAVES-1:0]      s_ready,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  input  logic                     err_clear,
  output logic                     err_flag,
  output logic [1:0]               err_cause,
  output logic [31:0]              err_addr
);

  localparam int                IDX_W      = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int                CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_flag_q;
  err_cause_e         err_cause_q, err_cause_d;
  logic [31:0]        err_addr_q;
  logic               err_set;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic               dec_ro;
  logic               is_write;

  mem_bus_decode #(
    .N_SLAVES       (N_SLAVES),
    .DECODE_BITS    (DECODE_BITS),
    .SLAVE_IDS      (SLAVE_IDS),
    .READ_ONLY_MASK (READ_ONLY_MASK)
  ) u_decode (
    .region    (cpu.cpu_addr[31 -: DECODE_BITS]),
    .hit       (dec_hit),
    .idx       (dec_idx),
    .read_only (dec_ro)
  );

  assign is_write = |cpu.cpu_wstrb;

  // Next-state logic. DONE never looks at cpu_valid, so the stale request
  // still held by the CPU during the ready pulse cannot be issued twice.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_set     = 1'b0;
    err_cause_d = err_cause_q;
    unique case (state_q)
      IDLE: begin
        if (cpu.cpu_valid) begin
          if (!dec_hit) begin
            state_d     = DONE;
            rdata_d     = ERROR_WORD;
            err_set     = 1'b1;
            err_cause_d = ERR_UNMAPPED;
          end else if (dec_ro && is_write) begin
            state_d     = DONE;
            rdata_d     = ERROR_WORD;
            err_set     = 1'b1;
            err_cause_d = ERR_RO_WRITE;
          end else begin
            state_d = ACCESS;
            idx_d   = dec_idx;
            cnt_d   = '0;
          end
        end
      end
      ACCESS: begin
        // A withdrawn request is a CPU protocol violation: drop it silently.
        if (!cpu.cpu_valid) begin
          state_d = IDLE;
        end else if (s_ready[idx_q]) begin
          state_d = DONE;
          rdata_d = s_rdata[idx_q*DATA_W +: DATA_W];
        end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
          state_d     = DONE;
          rdata_d     = ERROR_WORD;
          err_set     = 1'b1;
          err_cause_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state here is control or a single data word, so everything is
  // reset; there is no storage array whose reset would be wasteful.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_flag_q  <= 1'b0;
      err_cause_q <= ERR_NONE;
      err_addr_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples values from
      // before this edge, independent of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      // A new error outranks a simultaneous clear.
      if (err_set) begin
        err_flag_q  <= 1'b1;
        err_cause_q <= err_cause_d;
        err_addr_q  <= cpu.cpu_addr;
      end else if (err_clear) begin
        err_flag_q <= 1'b0;
      end
    end
  end

  // Gating with cpu_valid keeps a withdrawn request from reaching the slave.
  always_comb begin
    s_valid = '0;
    if (state_q == ACCESS && cpu.cpu_valid) s_valid[idx_q] = 1'b1;
  end

  assign s_addr        = cpu.cpu_addr;
  assign s_wdata       = cpu.cpu_wdata;
  assign s_wstrb       = (|s_valid) ? cpu.cpu_wstrb : '0;
  assign cpu.cpu_ready = (state_q == DONE);
  assign cpu.cpu_rdata = rdata_q;
  assign err_flag      = err_flag_q;
  assign err_cause     = err_cause_q;
  assign err_addr      = err_addr_q;

endmodule
